uart_baud_ctrl: RTL and testbench

UART_BAUD_CTRL -- requirements
Module: uart_baud_ctrl

---
 rtl/uart_baud_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_baud_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_ctrl.sv
// UART baud-rate controller: code-to-divisor lookup, deferred divisor
// change (applied only while both engines are idle), and a bit timer
// producing full-bit and mid-bit tick pulses.
module uart_baud_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_data,
    input  logic        tx_busy,
    input  logic        rx_busy,
    input  logic        rx_sync,
    output logic        baud_tick,
    output logic        half_tick,
    output logic [3:0]  cur_code,
    output logic [18:0] divisor,
    output logic        cfg_pending,
    output logic        cfg_err
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [3:0]  RST_CODE = 4'd4;
    localparam logic [18:0] RST_DIV  = 19'd10417;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_pend_code;
    logic [3:0]  r_cur_code;
    logic [18:0] r_divisor;
    logic [18:0] r_cnt;
    logic        r_baud_tick;
    logic        r_half_tick;
    logic        r_cfg_pending;
    logic        r_cfg_err;

    logic        w_cfg_valid;
    logic        w_cfg_bad;
    logic        w_wrap;
    logic        w_half_hit;
    logic        w_tick_ok;

    function automatic logic [18:0] f_code_div(input logic [3:0] code);
        case (code)
            4'd0:    f_code_div = 19'd333333;
            4'd1:    f_code_div = 19'd83333;
            4'd2:    f_code_div = 19'd41667;
            4'd3:    f_code_div = 19'd20833;
            4'd4:    f_code_div = 19'd10417;
            4'd5:    f_code_div = 19'd5208;
            4'd6:    f_code_div = 19'd2604;
            4'd7:    f_code_div = 19'd1736;
            4'd8:    f_code_div = 19'd868;
            4'd9:    f_code_div = 19'd434;
            4'd10:   f_code_div = 19'd217;
            4'd11:   f_code_div = 19'd109;
            default: f_code_div = RST_DIV;
        endcase
    endfunction

    assign w_cfg_valid = cfg_we && (cfg_data <= 4'd11);
    assign w_cfg_bad   = cfg_we && (cfg_data > 4'd11);
    assign w_wrap      = (r_cnt == r_divisor - 19'd1);
    assign w_half_hit  = (r_cnt == (r_divisor >> 1) - 19'd1);

    // Ticks are suppressed when the count is being realigned, during LOAD,
    // and on the edge entering LOAD so no pulse is visible while loading.
    assign w_tick_ok = (r_state != ST_LOAD) && (w_state_nxt != ST_LOAD) && !rx_sync;

    // Next-state selection for the deferred-reconfiguration FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_cfg_valid) w_state_nxt = ST_PEND;
            ST_PEND: if (!tx_busy && !rx_busy) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = w_cfg_valid ? ST_PEND : ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State, pending code and applied configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pend_code   <= RST_CODE;
            r_cur_code    <= RST_CODE;
            r_divisor     <= RST_DIV;
            r_cfg_pending <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cfg_pending <= (w_state_nxt != ST_RUN);
            r_cfg_err     <= w_cfg_bad;
            if (w_cfg_valid) begin
                r_pend_code <= cfg_data;
            end
            // LOAD applies the code held before this cycle's write, so a
            // write landing in LOAD becomes the next pending request.
            if (r_state == ST_LOAD) begin
                r_cur_code <= r_pend_code;
                r_divisor  <= f_code_div(r_pend_code);
            end
        end
    end

    // Bit timer and registered tick pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_baud_tick <= 1'b0;
            r_half_tick <= 1'b0;
        end else begin
            if ((r_state == ST_LOAD) || rx_sync || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 19'd1;
            end
            r_baud_tick <= w_tick_ok && w_wrap;
            r_half_tick <= w_tick_ok && w_half_hit;
        end
    end

    assign baud_tick   = r_baud_tick;
    assign half_tick   = r_half_tick;
    assign cur_code    = r_cur_code;
    assign divisor     = r_divisor;
    assign cfg_pending = r_cfg_pending;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl: a table of code writes with
// hand-computed results, plus directed multi-cycle timing sequences.
module tb_uart_baud_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_data = 4'd0;
    logic        tx_busy = 1'b0;
    logic        rx_busy = 1'b0;
    logic        rx_sync = 1'b0;
    logic        baud_tick;
    logic        half_tick;
    logic [3:0]  cur_code;
    logic [18:0] divisor;
    logic        cfg_pending;
    logic        cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  code;
        logic        valid;
        logic [3:0]  exp_code;
        logic [18:0] exp_div;
    } vec_t;

    vec_t vecs[16];

    uart_baud_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_data    (cfg_data),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .rx_sync     (rx_sync),
        .baud_tick   (baud_tick),
        .half_tick   (half_tick),
        .cur_code    (cur_code),
        .divisor     (divisor),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Steps until the chosen tick (0 = baud, 1 = half) is seen; n = -1 on timeout.
    task automatic wait_sig(input int which, input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!seen) begin
                step();
                if ((which == 0 && baud_tick) || (which == 1 && half_tick)) begin
                    seen = 1'b1;
                    n = i;
                end
            end
        end
    endtask

    initial begin
        int n;
        int bad_tick;
        int bad_cfg;
        logic exp_b;
        logic exp_h;

        vecs[0]  = '{4'd0,  1'b1, 4'd0,  19'd333333};
        vecs[1]  = '{4'd1,  1'b1, 4'd1,  19'd83333};
        vecs[2]  = '{4'd2,  1'b1, 4'd2,  19'd41667};
        vecs[3]  = '{4'd12, 1'b0, 4'd2,  19'd41667};
        vecs[4]  = '{4'd3,  1'b1, 4'd3,  19'd20833};
        vecs[5]  = '{4'd4,  1'b1, 4'd4,  19'd10417};
        vecs[6]  = '{4'd5,  1'b1, 4'd5,  19'd5208};
        vecs[7]  = '{4'd13, 1'b0, 4'd5,  19'd5208};
        vecs[8]  = '{4'd6,  1'b1, 4'd6,  19'd2604};
        vecs[9]  = '{4'd7,  1'b1, 4'd7,  19'd1736};
        vecs[10] = '{4'd8,  1'b1, 4'd8,  19'd868};
        vecs[11] = '{4'd14, 1'b0, 4'd8,  19'd868};
        vecs[12] = '{4'd9,  1'b1, 4'd9,  19'd434};
        vecs[13] = '{4'd10, 1'b1, 4'd10, 19'd217};
        vecs[14] = '{4'd11, 1'b1, 4'd11, 19'd109};
        vecs[15] = '{4'd15, 1'b0, 4'd11, 19'd109};

        // Reset state, with reset overriding a simultaneous write and rx_sync
        steps(2);
        cfg_we = 1'b1; cfg_data = 4'd11; rx_sync = 1'b1;
        step();
        cfg_we = 1'b0; rx_sync = 1'b0;
        chk("rst_code", 32'(cur_code), 32'd4);
        chk("rst_div", 32'(divisor), 32'd10417);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_ticks", {30'd0, baud_tick, half_tick}, 32'd0);

        // Default-rate tick spacing from reset release
        reset = 1'b0;
        cyc = 0;
        wait_sig(1, 6000, n);  chk("def_half_first", 32'(n), 32'd5208);
        wait_sig(0, 6000, n);  chk("def_baud_first", 32'(n), 32'd5209);
        wait_sig(1, 6000, n);  chk("def_half_second", 32'(n), 32'd5208);
        wait_sig(0, 6000, n);  chk("def_baud_second", 32'(n), 32'd5209);

        // Write code 8 while tx busy: old timing holds until the link idles
        steps(27834 - cyc);
        tx_busy = 1'b1;
        cfg_we = 1'b1; cfg_data = 4'd8;
        bad_tick = 0;
        bad_cfg = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            cfg_we = 1'b0;
            exp_b = ((cyc % 10417) == 0);
            exp_h = ((cyc % 10417) == 5208);
            if (baud_tick !== exp_b || half_tick !== exp_h) bad_tick++;
            if (cfg_pending !== 1'b1 || divisor !== 19'd10417 || cur_code !== 4'd4) bad_cfg++;
        end
        chk("busy_tick_cycles_bad", 32'(bad_tick), 32'd0);
        chk("busy_cfg_cycles_bad", 32'(bad_cfg), 32'd0);
        tx_busy = 1'b0;
        step();
        chk("busy_load_div_old", 32'(divisor), 32'd10417);
        chk("busy_load_pending", 32'(cfg_pending), 32'd1);
        chk("busy_load_ticks", {30'd0, baud_tick, half_tick}, 32'd0);
        step();
        chk("busy_new_div", 32'(divisor), 32'd868);
        chk("busy_new_code", 32'(cur_code), 32'd8);
        chk("busy_new_pending", 32'(cfg_pending), 32'd0);
        wait_sig(0, 1000, n);  chk("div868_first_baud", 32'(n), 32'd868);

        // Table of idle-link writes, valid and rejected codes
        for (int v = 0; v < 16; v++) begin
            cfg_we = 1'b1; cfg_data = vecs[v].code;
            step();
            cfg_we = 1'b0;
            chk($sformatf("tbl%0d_err", v), 32'(cfg_err), 32'(!vecs[v].valid));
            chk($sformatf("tbl%0d_pending", v), 32'(cfg_pending), 32'(vecs[v].valid));
            step();
            if (vecs[v].valid) chk($sformatf("tbl%0d_load_baud", v), 32'(baud_tick), 32'd0);
            else               chk($sformatf("tbl%0d_err_gone", v), 32'(cfg_err), 32'd0);
            step();
            chk($sformatf("tbl%0d_code", v), 32'(cur_code), 32'(vecs[v].exp_code));
            chk($sformatf("tbl%0d_div", v), 32'(divisor), 32'(vecs[v].exp_div));
            chk($sformatf("tbl%0d_pending_done", v), 32'(cfg_pending), 32'd0);
        end

        // Code 11 from idle: one PEND cycle, one LOAD cycle, then 109-clock bits
        cfg_we = 1'b1; cfg_data = 4'd11;
        step();
        cfg_we = 1'b0;
        chk("c11_pend", 32'(cfg_pending), 32'd1);
        step();
        chk("c11_load_pending", 32'(cfg_pending), 32'd1);
        chk("c11_load_ticks", {30'd0, baud_tick, half_tick}, 32'd0);
        step();
        chk("c11_div", 32'(divisor), 32'd109);
        chk("c11_pending_done", 32'(cfg_pending), 32'd0);
        wait_sig(1, 200, n);  chk("c11_half_first", 32'(n), 32'd54);
        wait_sig(0, 200, n);  chk("c11_baud_first", 32'(n), 32'd55);
        wait_sig(0, 200, n);  chk("c11_baud_period", 32'(n), 32'd109);

        // rx_sync at cnt 80 realigns the timer
        steps(80);
        rx_sync = 1'b1;
        step();
        rx_sync = 1'b0;
        chk("sync80_no_tick", {30'd0, baud_tick, half_tick}, 32'd0);
        wait_sig(0, 200, n);  chk("sync80_next_baud", 32'(n), 32'd109);

        // rx_sync at cnt 108 wins over the wrap and swallows that tick
        steps(108);
        rx_sync = 1'b1;
        step();
        rx_sync = 1'b0;
        chk("sync108_no_tick", 32'(baud_tick), 32'd0);
        wait_sig(1, 200, n);  chk("sync108_next_half", 32'(n), 32'd54);

        // Two writes during PEND (last wins), then a write landing in LOAD
        rx_busy = 1'b1;
        cfg_we = 1'b1; cfg_data = 4'd9;
        step();
        cfg_data = 4'd10;
        step();
        cfg_we = 1'b0; rx_busy = 1'b0;
        chk("pend2_code_old", 32'(cur_code), 32'd11);
        step();
        cfg_we = 1'b1; cfg_data = 4'd11;
        step();
        cfg_we = 1'b0;
        chk("pend2_code", 32'(cur_code), 32'd10);
        chk("pend2_div", 32'(divisor), 32'd217);
        chk("loadwr_pending", 32'(cfg_pending), 32'd1);
        steps(2);
        chk("loadwr_code", 32'(cur_code), 32'd11);
        chk("loadwr_div", 32'(divisor), 32'd109);
        chk("loadwr_pending_done", 32'(cfg_pending), 32'd0);

        // Reset while a change is pending discards it
        rx_busy = 1'b1;
        cfg_we = 1'b1; cfg_data = 4'd3;
        step();
        cfg_we = 1'b0;
        chk("rstpend_pending", 32'(cfg_pending), 32'd1);
        reset = 1'b1;
        step();
        chk("rstpend_code", 32'(cur_code), 32'd4);
        chk("rstpend_div", 32'(divisor), 32'd10417);
        chk("rstpend_pending_clr", 32'(cfg_pending), 32'd0);
        reset = 1'b0; rx_busy = 1'b0;
        steps(3);
        chk("rstpend_code_after", 32'(cur_code), 32'd4);
        chk("rstpend_pending_after", 32'(cfg_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
